// File: rtl/fnd_pkg.sv
// Shared FND segment definitions used by the segment encoder and by fnd_reader.
// Patterns are in g..a bit order (bit 6 = g, bit 0 = a) and active-low (0 = lit).
package fnd_pkg;

  localparam int FND_W  = 7;
  localparam int CODE_W = 4;

  localparam logic [FND_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [FND_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [FND_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [FND_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [FND_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [FND_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [FND_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [FND_W-1:0] SEG_7     = 7'b1011000;
  localparam logic [FND_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [FND_W-1:0] SEG_9     = 7'b0011000;
  localparam logic [FND_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [FND_W-1:0] SEG_BLANK = 7'b1111111;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic              err;
    logic [CODE_W-1:0] code;
  } seg_decode_t;

endpackage

// File: rtl/fnd_reader_if.sv
// Bus between a multiplexed FND display source and fnd_reader.
// Optional feature macro: FND_READER_ERRCNT_EN adds the o_ErrCnt signal.
//
// Handshake: there is no back-pressure. o_Valid is a one-cycle strobe, high on
// the cycle after the edge that commits the last not-yet-seen digit of a frame;
// o_Data/o_Err are valid and already hold that frame on the same cycle, and a
// consumer must sample them while o_Valid is high.
interface fnd_reader_if #(
  parameter int DIGITS = 4
);

  logic [fnd_pkg::FND_W-1:0]  i_FND;
  logic [DIGITS-1:0]          i_Com;
  logic [4*DIGITS-1:0]        o_Data;
  logic [DIGITS-1:0]          o_Err;
  logic                       o_Valid;
`ifdef FND_READER_ERRCNT_EN
  logic [7:0]                 o_ErrCnt;
`endif

`ifdef FND_READER_ERRCNT_EN
  modport master (output i_FND, i_Com, input o_Data, o_Err, o_Valid, o_ErrCnt);
  modport slave  (input i_FND, i_Com, output o_Data, o_Err, o_Valid, o_ErrCnt);
`else
  modport master (output i_FND, i_Com, input o_Data, o_Err, o_Valid);
  modport slave  (input i_FND, i_Com, output o_Data, o_Err, o_Valid);
`endif

endinterface

// File: rtl/fnd_seg_decode.sv
// Combinational segment-pattern to hex-code decoder; inverse of the FND encoder.
// Unknown patterns (including blank) decode to F with err set.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [FND_W-1:0] i_seg,
  output seg_decode_t      o_dec
);

  // Table lookup; the fallback glyph F is legal, everything unlisted is an error.
  always_comb begin
    o_dec.err  = 1'b0;
    o_dec.code = 4'hF;
    case (i_seg)
      SEG_0:   o_dec.code = 4'h0;
      SEG_1:   o_dec.code = 4'h1;
      SEG_2:   o_dec.code = 4'h2;
      SEG_3:   o_dec.code = 4'h3;
      SEG_4:   o_dec.code = 4'h4;
      SEG_5:   o_dec.code = 4'h5;
      SEG_6:   o_dec.code = 4'h6;
      SEG_7:   o_dec.code = 4'h7;
      SEG_8:   o_dec.code = 4'h8;
      SEG_9:   o_dec.code = 4'h9;
      SEG_F:   o_dec.code = 4'hF;
      default: begin
        o_dec.code = 4'hF;
        o_dec.err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_reader.sv
// fnd_reader: recovers the hex digits shown on a multiplexed active-low
// 7-segment bus. A sample must repeat STABLE_CNT times in a row before it is
// committed, so scan-transition glitches never reach o_Data.
// Optional feature macro: FND_READER_ERRCNT_EN (saturating invalid-commit counter).
module fnd_reader
  import fnd_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4   // legal range 1..15
)(
  input  logic          i_Clk,
  input  logic          i_Rst,
  fnd_reader_if.slave   bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  // Input stage and one-sample history.
  logic [FND_W-1:0]    r_fnd_q, r_fnd_d;
  logic [DIGITS-1:0]   r_com_q, r_com_d;
  logic [FND_W-1:0]    prev_fnd_q, prev_fnd_d;
  logic [DIGITS-1:0]   prev_com_q, prev_com_d;

  // Stability counter, committed digits and frame tracking.
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                valid_q, valid_d;

  logic                com_onehot;
  logic                same_sample;
  logic                commit;
  logic [DIGITS-1:0]   mask_all;
  seg_decode_t         dec;

  fnd_seg_decode u_dec (
    .i_seg (r_fnd_q),
    .o_dec (dec)
  );

  // Classify the registered sample: exactly one common lit, and same as last cycle.
  always_comb begin
    com_onehot  = (r_com_q != '0) && ((r_com_q & (r_com_q - DIGITS'(1))) == '0);
    same_sample = (r_com_q == prev_com_q) && (r_fnd_q == prev_fnd_q);
  end

  // Input pipeline: register the bus and keep the previous registered sample.
  always_comb begin
    r_fnd_d    = bus.i_FND;
    r_com_d    = bus.i_Com;
    prev_fnd_d = r_fnd_q;
    prev_com_d = r_com_q;
  end

  // Stability counter; saturates at STABLE so a held sample commits only once.
  always_comb begin
    cnt_d = cnt_q;
    if (!com_onehot) begin
      cnt_d = 4'd0;
    end else if (same_sample && (cnt_q != 4'd0)) begin
      cnt_d = (cnt_q >= STABLE) ? STABLE : (cnt_q + 4'd1);
    end else begin
      cnt_d = 4'd1;
    end
  end

  // Commit when the count reaches STABLE, except while it is merely held there.
  // With STABLE=1 a restart lands directly on STABLE, so every change commits.
  always_comb begin
    commit = com_onehot && (cnt_d == STABLE) && !(same_sample && (cnt_q == STABLE));
  end

  // Write the selected digit slot and update the frame mask / valid strobe.
  always_comb begin
    data_d   = data_q;
    err_d    = err_q;
    mask_d   = mask_q;
    valid_d  = 1'b0;
    mask_all = mask_q | r_com_q;
    if (commit) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (r_com_q[k]) begin
          data_d[4*k +: 4] = dec.code;
          err_d[k]         = dec.err;
        end
      end
      if (&mask_all) begin
        valid_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d  = mask_all;
      end
    end
  end

  // State registers; reset takes priority over a commit on the same edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_fnd_q    <= '0;
      r_com_q    <= '0;
      prev_fnd_q <= '0;
      prev_com_q <= '0;
      cnt_q      <= 4'd0;
      data_q     <= '1;
      err_q      <= '0;
      mask_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      r_fnd_q    <= r_fnd_d;
      r_com_q    <= r_com_d;
      prev_fnd_q <= prev_fnd_d;
      prev_com_q <= prev_com_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.o_Data  = data_q;
  assign bus.o_Err   = err_q;
  assign bus.o_Valid = valid_q;

`ifdef FND_READER_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Count commits of illegal patterns, holding at 255.
  always_comb begin
    errcnt_d = errcnt_q;
    if (commit && dec.err && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      errcnt_q <= 8'd0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.o_ErrCnt = errcnt_q;
`endif

endmodule

// File: tb/tb_fnd_reader.sv
// Testbench for fnd_reader (DIGITS=4, STABLE_CNT=4).
// Reference model: a sample commits when it has been seen exactly STABLE_CNT
// consecutive times as a valid one-hot sample (the registered sample lags the
// bus by one edge). Frame data is queued on predicted o_Valid pulses.
module tb_fnd_reader;
  import fnd_pkg::*;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fnd_reader_if #(.DIGITS(DIGITS)) bus ();

  fnd_reader #(.DIGITS(DIGITS), .STABLE_CNT(STABLE)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [10:0] m_stage, m_last;
  int          m_run;
  logic [15:0] m_data;
  logic [3:0]  m_err, m_mask;
  logic        m_valid;
  int          m_errcnt;
  logic [4:0]  dec_tab [128];
  logic [15:0] exp_q [$];
  logic [6:0]  glyph [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot4(input logic [3:0] c);
    return $countones(c) == 1;
  endfunction

  function automatic int digit_of(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return 0;
  endfunction

  // Model update at an active edge, using the bus values present at that edge.
  task automatic model_edge();
    logic [10:0] s;
    int d;
    if (rst) begin
      m_stage = '0; m_last = '0; m_run = 0;
      m_data = 16'hFFFF; m_err = '0; m_mask = '0; m_valid = 1'b0; m_errcnt = 0;
      return;
    end
    s       = m_stage;
    m_stage = {bus.i_Com, bus.i_FND};
    m_valid = 1'b0;
    if (onehot4(s[10:7])) m_run = (s == m_last) ? m_run + 1 : 1;
    else                  m_run = 0;
    m_last = s;
    if (onehot4(s[10:7]) && m_run == STABLE) begin
      d = digit_of(s[10:7]);
      m_data[4*d +: 4] = dec_tab[s[6:0]][3:0];
      m_err[d]         = dec_tab[s[6:0]][4];
      if (dec_tab[s[6:0]][4] && m_errcnt < 255) m_errcnt++;
      m_mask = m_mask | s[10:7];
      if (m_mask == 4'hF) begin
        m_valid = 1'b1;
        m_mask  = '0;
        exp_q.push_back(m_data);
      end
    end
  endtask

  // Compare every DUT output against the model; score valid-frame contents.
  task automatic check_all();
    logic [15:0] f;
    chk("data", bus.o_Data, m_data);
    chk("err", bus.o_Err, m_err);
    chk("valid", bus.o_Valid, m_valid);
`ifdef FND_READER_ERRCNT_EN
    chk("errcnt", bus.o_ErrCnt, m_errcnt);
`endif
    if (bus.o_Valid) begin
      if (exp_q.size() == 0) chk("valid_spurious", 1, 0);
      else begin
        f = exp_q.pop_front();
        chk("frame_data", bus.o_Data, f);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] com, input logic [6:0] fnd);
    bus.i_Com = com;
    bus.i_FND = fnd;
  endtask

  typedef struct {
    logic [3:0]  com;
    logic [6:0]  fnd;
    int          hold;
    logic [15:0] exp_data;
    logic [3:0]  exp_err;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int pulses;
    glyph = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9, SEG_F};
    for (int i = 0; i < 128; i++) dec_tab[i] = {1'b1, 4'hF};
    for (int i = 0; i < 11; i++) dec_tab[glyph[i]] = {1'b0, (i == 10) ? 4'hF : 4'(i)};

    // Scan vectors; the bench enters them with digit0=3 already committed.
    vecs[0] = '{4'b0001, SEG_1,     5,  16'hFFF1, 4'b0000, 0};
    vecs[1] = '{4'b0010, SEG_2,     5,  16'hFF21, 4'b0000, 0};
    vecs[2] = '{4'b0100, SEG_3,     5,  16'hF321, 4'b0000, 0};
    vecs[3] = '{4'b1000, SEG_4,     5,  16'h4321, 4'b0000, 1};
    vecs[4] = '{4'b0011, SEG_5,     10, 16'h4321, 4'b0000, 0};
    vecs[5] = '{4'b0100, SEG_BLANK, 5,  16'h4F21, 4'b0100, 0};
    vecs[6] = '{4'b1000, SEG_F,     5,  16'hFF21, 4'b0100, 0};
    vecs[7] = '{4'b0000, SEG_8,     3,  16'hFF21, 4'b0100, 0};
    vecs[8] = '{4'b0001, SEG_8,     5,  16'hFF28, 4'b0100, 0};
    vecs[9] = '{4'b0010, SEG_9,     5,  16'hFF98, 4'b0100, 1};

    // Reset, then idle with no common selected.
    drive(4'b0000, SEG_BLANK);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("reset_data", bus.o_Data, 16'hFFFF);
    chk("reset_err", bus.o_Err, 4'b0000);

    // Single-digit latency: digit0 shows 3 exactly at edge STABLE+1.
    drive(4'b0001, SEG_3);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("lat_d0", bus.o_Data[3:0], (e >= STABLE + 1) ? 4'h3 : 4'hF);
      chk("lat_valid", bus.o_Valid, 1'b0);
    end
    chk("lat_err0", bus.o_Err[0], 1'b0);

    // Table-driven scan and corner patterns.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].com, vecs[v].fnd);
      pulses = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        tick();
        if (bus.o_Valid) pulses++;
      end
      chk($sformatf("vec%0d_data", v), bus.o_Data, vecs[v].exp_data);
      chk($sformatf("vec%0d_err", v), bus.o_Err, vecs[v].exp_err);
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
    end
`ifdef FND_READER_ERRCNT_EN
    chk("errcnt_blank", bus.o_ErrCnt, 8'd1);
`endif

    // Digit1 dwell with a one-cycle glitch on its second cycle.
    drive(4'b0010, SEG_5);
    tick();
    drive(4'b0010, SEG_6);
    tick();
    drive(4'b0010, SEG_5);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("glitch_d1", bus.o_Data[7:4], (e >= STABLE + 1) ? 4'h5 : 4'h9);
    end

    // Reset with cnt=3 of a dwell; reset lands on the would-be commit edge.
    drive(4'b0100, SEG_7);
    for (int e = 0; e < STABLE; e++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_data", bus.o_Data, 16'hFFFF);
    chk("rst_mid_err", bus.o_Err, 4'b0000);
    chk("rst_mid_valid", bus.o_Valid, 1'b0);
    rst = 1'b0;
    for (int e = 0; e < STABLE - 1; e++) tick();
    chk("rst_restart", bus.o_Data, 16'hFFFF);
    tick();
    tick();
    chk("rst_recommit", bus.o_Data[11:8], 4'h7);

    // Randomized scanning against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] com;
      logic [6:0] fnd;
      case ($urandom_range(0, 9))
        0:       com = 4'($urandom_range(0, 15));
        1:       com = 4'b0000;
        default: com = 4'(1 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) fnd = 7'($urandom_range(0, 127));
      else                           fnd = glyph[$urandom_range(0, 10)];
      drive(com, fnd);
      if ($urandom_range(0, 60) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 1; c < $urandom_range(1, 7); c++) tick();
    end

    chk("frames_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
